muldiv_hilo: RTL

Iterative multiply/divide unit with the architectural HI/LO register pair. It executes the mult, multu, div, divu, mthi, mtlo, mfhi and mflo strobes produced by the instruction decoder. Each multiply or divide runs for 33 cycles. During that time the unit raises `stall` to freeze the pipeline whenever another HI/LO-touching instruction arrives. The unit sits in the execute stage, beside the ALU; `rdata` feeds the register-file write-data mux.

---
 rtl/muldiv_hilo.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit holding the architectural HI/LO pair.
//
// Multiplies use shift-add and divides use restoring division, one bit per cycle.
// Each operation takes 32 iteration cycles plus one FIX cycle. FIX applies the
// result signs and writes HI/LO.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   mult, multu, div, divu      decoded start strobes (priority in that order)
//   mthi, mtlo, mfhi, mflo      decoded HI/LO move strobes
//   flush                       abort any in-flight operation, no HI/LO write
//   a, b                        rs / rt operands
//   rdata                       mfhi/mflo read data (combinational from HI/LO)
//   busy                        operation in progress
//   stall                       pipeline hold request (busy and any strobe)
//   hi, lo                      architectural HI/LO registers
module muldiv_hilo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Two's-complement negation when c is set.
    function automatic logic [31:0] neg_if32(input logic c, input logic [31:0] v);
        return c ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg_if64(input logic c, input logic [63:0] v);
        return c ? (~v + 64'd1) : v;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] prod_q, prod_d;     // upper: accumulator, lower: remaining multiplier bits
    logic [31:0] opnd_q, opnd_d;     // |a| for multiply, |b| (divisor) for divide
    logic [32:0] rem_q, rem_d;       // partial remainder
    logic [31:0] quo_q, quo_d;       // dividend shifts out as quotient shifts in
    logic [31:0] a_raw_q, a_raw_d;   // raw dividend, returned in HI on divide by zero
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;

    logic        start_s;
    logic        start_div_s;
    logic        start_sgn_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic        div_ge_s;

    // Operand decode, magnitudes and the per-cycle datapath terms.
    always_comb begin
        start_s     = mult | multu | div | divu;
        start_div_s = ~(mult | multu);
        start_sgn_s = mult | (~multu & div);
        abs_a_s     = neg_if32(start_sgn_s & a[31], a);
        abs_b_s     = neg_if32(start_sgn_s & b[31], b);
        mul_sum_s   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift_s = {rem_q[31:0], quo_q[31]};
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    end

    // Next-state logic: start/move decode, iteration and sign fix-up.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    // flush suppresses both starts and HI/LO moves
                    state_d = IDLE;
                end else if (start_s) begin
                    cnt_d     = 5'd0;
                    a_raw_d   = a;
                    is_div_d  = start_div_s;
                    neg_res_d = start_sgn_s & (a[31] ^ b[31]);
                    neg_rem_d = start_sgn_s & a[31];
                    dz_d      = start_div_s & (b == 32'd0);
                    if (start_div_s) begin
                        quo_d   = abs_a_s;
                        opnd_d  = abs_b_s;
                        rem_d   = 33'd0;
                        state_d = DIV;
                    end else begin
                        prod_d  = {32'd0, abs_b_s};
                        opnd_d  = abs_a_s;
                        state_d = MUL;
                    end
                end else if (mthi) begin
                    hi_d = a;
                end else if (mtlo) begin
                    lo_d = a;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    if (state_q == MUL) begin
                        prod_d = {mul_sum_s, prod_q[31:1]};
                    end else begin
                        rem_d = div_ge_s ? div_diff_s : div_shift_s;
                        quo_d = {quo_q[30:0], div_ge_s};
                    end
                    if (cnt_q == 5'd31) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
                if (flush) begin
                    hi_d = hi_q;
                end else if (dz_q) begin
                    hi_d = a_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else if (is_div_q) begin
                    hi_d = neg_if32(neg_rem_q, rem_q[31:0]);
                    lo_d = neg_if32(neg_res_q, quo_q);
                end else begin
                    {hi_d, lo_d} = neg_if64(neg_res_q, prod_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            prod_q    <= 64'd0;
            opnd_q    <= 32'd0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            a_raw_q   <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            prod_q    <= prod_d;
            opnd_q    <= opnd_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    // Outputs: HI/LO straight from flops; stall and rdata stay combinational.
    always_comb begin
        hi    = hi_q;
        lo    = lo_q;
        busy  = (state_q != IDLE);
        stall = busy & (mult | multu | div | divu | mthi | mtlo | mfhi | mflo);
        if (mfhi) begin
            rdata = hi_q;
        end else if (mflo) begin
            rdata = lo_q;
        end else begin
            rdata = 32'd0;
        end
    end

endmodule
